data_path_v5: RTL and testbench

Processor datapath for the SPARC-subset core. It holds the architectural registers (IR, PSR, MAR, MDR, PC, nPC, TBR, WIM), a 32×32 register file, the ALU, the nPC/branch adders, a 6-bit trap queue and a byte-addressed RAM with an MFA/MFC handshake. An external control unit drives every select and enable and observes all register values.

---
 rtl/dp_pkg.sv | 42 ++++
 rtl/dp_regfile.sv | 33 +++
 rtl/data_path_v5.sv | 187 ++++++++++++++++++
 tb/tb_data_path_v5.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the data_path_v5 datapath.
// Holds the SPARC op3 codes the ALU understands, the encodings of the
// 2-bit datapath mux selects, PSR/TBR field positions and the trap-type
// priority encoder used to build the TBR tt field.
package dp_pkg;

  // op3 codes; bit 4 is the "set cc" variant and is masked off before decode
  localparam logic [5:0] OP3_ADD  = 6'h00;
  localparam logic [5:0] OP3_AND  = 6'h01;
  localparam logic [5:0] OP3_OR   = 6'h02;
  localparam logic [5:0] OP3_XOR  = 6'h03;
  localparam logic [5:0] OP3_SUB  = 6'h04;
  localparam logic [5:0] OP3_ANDN = 6'h05;
  localparam logic [5:0] OP3_ORN  = 6'h06;
  localparam logic [5:0] OP3_XNOR = 6'h07;
  localparam logic [5:0] OP3_ADDX = 6'h08;
  localparam logic [5:0] OP3_SUBX = 6'h0C;
  localparam logic [5:0] OP3_SLL  = 6'h25;
  localparam logic [5:0] OP3_SRL  = 6'h26;
  localparam logic [5:0] OP3_SRA  = 6'h27;
  localparam logic [5:0] OP3_CC_MASK = 6'h2F;

  typedef enum logic [1:0] {CIN_PC, CIN_NPC, CIN_ALU, CIN_MDR} cin_sel_e;
  typedef enum logic [1:0] {RC_IR, RC_R18, RC_R17, RC_R15} rc_sel_e;
  typedef enum logic [1:0] {MAR_ALU, MAR_PC, MAR_AUX0, MAR_AUX1} mar_sel_e;
  typedef enum logic [1:0] {MDR_RAM, MDR_ALU, MDR_AUX0, MDR_AUX1} mdr_sel_e;
  typedef enum logic [1:0] {NPC_SEQ, NPC_TBR, NPC_BR0, NPC_BR1} npc_sel_e;

  // PSR: icc = {N,Z,V,C} at [23:20]; S, PS, ET, CWP in the low byte
  localparam int PSR_ICC_LO = 20;
  localparam logic [31:0] PSR_RESET = 32'h0000_0080;
  // TBR: TBA at [31:7], tt at [6:4], [3:0] always zero
  localparam int TBR_TBA_LO = 7;

  // tt = 1 + index of lowest pending trap, 0 when none pending
  function automatic logic [2:0] trap_type(input logic [5:0] q);
    trap_type = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (q[i]) trap_type = 3'(i + 1);
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// 2-read / 1-write register file for the datapath.
// Ports: clk, rst (sync active-high, clears every entry), w_en/w_addr/w_data
// write port, a_addr/b_addr combinational read addresses, a_data/b_data.
// r0 always reads zero and ignores writes; a same-edge write is seen by
// reads only after the edge.
module dp_regfile #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic [4:0]  a_addr,
  input  logic [4:0]  b_addr,
  output logic [31:0] a_data,
  output logic [31:0] b_data
);

  logic [31:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (w_en && w_addr != 5'd0 && int'(w_addr) < NREGS) begin
      regs[w_addr] <= w_data;
    end
  end

  assign a_data = (a_addr == 5'd0 || int'(a_addr) >= NREGS) ? '0 : regs[a_addr];
  assign b_data = (b_addr == 5'd0 || int'(b_addr) >= NREGS) ? '0 : regs[b_addr];

endmodule

// File: rtl/data_path_v5.sv
// SPARC-subset processor datapath: architectural registers, register file,
// ALU, nPC/branch adders, trap queue and a byte-addressed big-endian RAM
// with an MFA/MFC handshake. All control comes from an external unit.
// Ports: Clk/Clr (sync active-high reset); register value outputs IR..ALU;
// MFC handshake output; active-low load enables (*E) and clears; mux
// selects; external load data MDR_AUX/MAR_AUX/TBA_IN/tQ_IN/WIM_IN/CWP/OP1.
module data_path_v5 import dp_pkg::*; #(
  parameter int RAM_BYTES = 512,
  parameter int NREGS     = 32
) (
  input  logic        Clk,
  input  logic        Clr,
  output logic [31:0] IR, PSR, MAR, MDR, PC, nPC, TBR, WIM, TQ, ALU,
  output logic        MFC,
  input  logic        IRE, MDRE, TBRE, nPCE, PCE, MARE, tQE, PSRE, RFE, WIME,
  input  logic        ClrPC, nPCClr, IRClr, tQClr,
  input  logic        ALUE, MFA,
  input  logic        nPC_ADD, nPC_ADDSEL, TB_ADD, MOP_SEL, BAUX, RA_SEL,
  input  logic        DISP_SEL, AOP_SEL, ttAUX,
  input  logic        ET, PSR_SUPER, PSR_PREV_SUP,
  input  logic [1:0]  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL,
  input  logic [1:0]  PSR_SEL, TBA_SEL,
  input  logic [31:0] MDR_AUX, MAR_AUX,
  input  logic [4:0]  CWP,
  input  logic [5:0]  OP1,
  input  logic [24:0] TBA_IN,
  input  logic [5:0]  tQ_IN,
  input  logic [31:0] WIM_IN
);

  localparam int AW = $clog2(RAM_BYTES);

  logic [31:0] a_data, b_data, rf_wdata, op_b, simm, disp;
  logic [31:0] npc_next, mar_next, mdr_next, tbr_next, rd_word;
  logic [4:0]  a_addr, w_addr;
  logic [5:0]  op3, op_base, mop, tq;
  logic [32:0] sum;
  logic        is_add, is_sub, cin, fn, fz, fv, fc, mem_wr;
  logic [2:0]  tt;
  logic [7:0]  ram [RAM_BYTES];
  logic [AW-1:0] baddr [4];

  // ---------------- register file ----------------
  assign a_addr = RA_SEL ? IR[29:25] : IR[18:14];

  always_comb begin
    w_addr = IR[29:25];
    case (rc_sel_e'(RC_SEL))
      RC_IR:  w_addr = IR[29:25];
      RC_R18: w_addr = 5'd18;
      RC_R17: w_addr = 5'd17;
      RC_R15: w_addr = 5'd15;
    endcase
    rf_wdata = PC;
    case (cin_sel_e'(CIN_SEL))
      CIN_PC:  rf_wdata = PC;
      CIN_NPC: rf_wdata = nPC;
      CIN_ALU: rf_wdata = ALU;
      CIN_MDR: rf_wdata = MDR;
    endcase
  end

  dp_regfile #(.NREGS(NREGS)) u_rf (
    .clk(Clk), .rst(Clr), .w_en(!RFE), .w_addr(w_addr), .w_data(rf_wdata),
    .a_addr(a_addr), .b_addr(IR[4:0]), .a_data(a_data), .b_data(b_data)
  );

  // ---------------- ALU ----------------
  assign simm = {{19{IR[12]}}, IR[12:0]};
  assign cin  = PSR[PSR_ICC_LO];

  always_comb begin
    op3     = AOP_SEL ? OP3_ADD : IR[24:19];
    op_base = op3 & OP3_CC_MASK;
    case (ALU_SEL)
      2'd0:    op_b = b_data;
      2'd1:    op_b = IR[13] ? simm : b_data;
      2'd2:    op_b = 32'd4;
      default: op_b = '0;
    endcase
    // sum[32] is carry-out for adds and borrow for subtracts
    is_add = 1'b0;
    is_sub = 1'b0;
    sum    = '0;
    ALU    = '0;
    case (op_base)
      OP3_ADD:  begin is_add = 1'b1; sum = {1'b0, a_data} + {1'b0, op_b}; end
      OP3_ADDX: begin is_add = 1'b1; sum = {1'b0, a_data} + {1'b0, op_b} + {32'd0, cin}; end
      OP3_SUB:  begin is_sub = 1'b1; sum = {1'b0, a_data} - {1'b0, op_b}; end
      OP3_SUBX: begin is_sub = 1'b1; sum = {1'b0, a_data} - {1'b0, op_b} - {32'd0, cin}; end
      OP3_AND:  ALU = a_data & op_b;
      OP3_OR:   ALU = a_data | op_b;
      OP3_XOR:  ALU = a_data ^ op_b;
      OP3_ANDN: ALU = a_data & ~op_b;
      OP3_ORN:  ALU = a_data | ~op_b;
      OP3_XNOR: ALU = ~(a_data ^ op_b);
      OP3_SLL:  ALU = a_data << op_b[4:0];
      OP3_SRL:  ALU = a_data >> op_b[4:0];
      OP3_SRA:  ALU = $unsigned($signed(a_data) >>> op_b[4:0]);
      default:  begin is_add = 1'b1; sum = {1'b0, a_data} + {1'b0, op_b}; end
    endcase
    if (is_add || is_sub) ALU = sum[31:0];
    fn = ALU[31];
    fz = (ALU == 32'd0);
    fc = (is_add || is_sub) && sum[32];
    fv = (is_add && (a_data[31] == op_b[31]) && (ALU[31] != a_data[31])) ||
         (is_sub && (a_data[31] != op_b[31]) && (ALU[31] != a_data[31]));
  end

  // ---------------- next-value muxes ----------------
  assign disp = DISP_SEL ? {IR[29:0], 2'b00} : {{8{IR[21]}}, IR[21:0], 2'b00};
  assign tt   = trap_type(tq);
  assign tbr_next = {(TBA_SEL == 2'd1) ? TBA_IN : TBR[31:TBR_TBA_LO],
                     (ttAUX && !TB_ADD) ? tt : 3'd0, 4'b0000};

  always_comb begin
    npc_next = PC;
    case (npc_sel_e'(nPC_SEL))
      NPC_SEQ: npc_next = (nPC_ADDSEL ? nPC : PC) + (nPC_ADD ? 32'd4 : 32'd0);
      NPC_TBR: npc_next = TBR;
      NPC_BR0, NPC_BR1: npc_next = PC + (BAUX ? disp : 32'd0);
    endcase
    mar_next = MAR_AUX;
    case (mar_sel_e'(MAR_SEL))
      MAR_ALU: mar_next = ALU;
      MAR_PC:  mar_next = PC;
      MAR_AUX0, MAR_AUX1: mar_next = MAR_AUX;
    endcase
    mdr_next = MDR_AUX;
    case (mdr_sel_e'(MDR_SEL))
      MDR_RAM: mdr_next = rd_word;
      MDR_ALU: mdr_next = ALU;
      MDR_AUX0, MDR_AUX1: mdr_next = MDR_AUX;
    endcase
  end

  // ---------------- memory ----------------
  assign mop    = MOP_SEL ? OP1 : IR[24:19];
  assign mem_wr = mop[2];

  for (genvar k = 0; k < 4; k++) begin : g_baddr
    assign baddr[k] = AW'((MAR + 32'(k)) % 32'(RAM_BYTES));
  end

  // a reset edge aborts the access, so a write on that edge is dropped too
  always_ff @(posedge Clk) begin
    if (MFA && mem_wr && !Clr) begin
      ram[baddr[0]] <= MDR[31:24];
      ram[baddr[1]] <= MDR[23:16];
      ram[baddr[2]] <= MDR[15:8];
      ram[baddr[3]] <= MDR[7:0];
    end
  end

  // ---------------- architectural registers ----------------
  always_ff @(posedge Clk) begin
    if (Clr) begin
      IR <= '0; PSR <= PSR_RESET; MAR <= '0; MDR <= '0; PC <= '0; nPC <= '0;
      TBR <= '0; WIM <= '0; tq <= '0; rd_word <= '0; MFC <= 1'b0;
    end else begin
      MFC <= MFA;
      // read data is staged here and reaches MDR one edge later
      if (MFA && !mem_wr)
        rd_word <= {ram[baddr[0]], ram[baddr[1]], ram[baddr[2]], ram[baddr[3]]};
      if (!IRClr)      IR  <= '0;
      else if (!IRE)   IR  <= MDR;
      if (!ClrPC)      PC  <= '0;
      else if (!PCE)   PC  <= nPC;
      if (!nPCClr)     nPC <= '0;
      else if (!nPCE)  nPC <= npc_next;
      if (!tQClr)      tq  <= '0;
      else if (!tQE)   tq  <= tq | tQ_IN;
      if (!MARE) MAR <= mar_next;
      if (!MDRE) MDR <= mdr_next;
      if (!WIME) WIM <= WIM_IN;
      if (!TBRE) TBR <= tbr_next;
      if (!PSRE && PSR_SEL == 2'd1) PSR[7:0] <= {PSR_SUPER, PSR_PREV_SUP, ET, CWP};
      if (ALUE) PSR[PSR_ICC_LO +: 4] <= {fn, fz, fv, fc};
    end
  end

  assign TQ = {26'd0, tq};

  logic unused_ok;
  assign unused_ok = ^{mop[5:3], mop[1:0]};

endmodule

// File: tb/tb_data_path_v5.sv
module tb_data_path_v5;

  logic        Clk = 1'b0;
  logic        Clr;
  logic [31:0] IR, PSR, MAR, MDR, PC, nPC, TBR, WIM, TQ, ALU;
  logic        MFC;
  logic        IRE, MDRE, TBRE, nPCE, PCE, MARE, tQE, PSRE, RFE, WIME;
  logic        ClrPC, nPCClr, IRClr, tQClr, ALUE, MFA;
  logic        nPC_ADD, nPC_ADDSEL, TB_ADD, MOP_SEL, BAUX, RA_SEL, DISP_SEL, AOP_SEL, ttAUX;
  logic        ET, PSR_SUPER, PSR_PREV_SUP;
  logic [1:0]  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL, PSR_SEL, TBA_SEL;
  logic [31:0] MDR_AUX, MAR_AUX, WIM_IN;
  logic [4:0]  CWP;
  logic [5:0]  OP1, tQ_IN;
  logic [24:0] TBA_IN;

  always #5 Clk = ~Clk;

  data_path_v5 #(.RAM_BYTES(512), .NREGS(32)) dut (
    .Clk(Clk), .Clr(Clr),
    .IR(IR), .PSR(PSR), .MAR(MAR), .MDR(MDR), .PC(PC), .nPC(nPC), .TBR(TBR),
    .WIM(WIM), .TQ(TQ), .ALU(ALU), .MFC(MFC),
    .IRE(IRE), .MDRE(MDRE), .TBRE(TBRE), .nPCE(nPCE), .PCE(PCE), .MARE(MARE),
    .tQE(tQE), .PSRE(PSRE), .RFE(RFE), .WIME(WIME),
    .ClrPC(ClrPC), .nPCClr(nPCClr), .IRClr(IRClr), .tQClr(tQClr),
    .ALUE(ALUE), .MFA(MFA),
    .nPC_ADD(nPC_ADD), .nPC_ADDSEL(nPC_ADDSEL), .TB_ADD(TB_ADD), .MOP_SEL(MOP_SEL),
    .BAUX(BAUX), .RA_SEL(RA_SEL), .DISP_SEL(DISP_SEL), .AOP_SEL(AOP_SEL), .ttAUX(ttAUX),
    .ET(ET), .PSR_SUPER(PSR_SUPER), .PSR_PREV_SUP(PSR_PREV_SUP),
    .nPC_SEL(nPC_SEL), .ALU_SEL(ALU_SEL), .CIN_SEL(CIN_SEL), .RC_SEL(RC_SEL),
    .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL), .PSR_SEL(PSR_SEL), .TBA_SEL(TBA_SEL),
    .MDR_AUX(MDR_AUX), .MAR_AUX(MAR_AUX), .CWP(CWP), .OP1(OP1), .TBA_IN(TBA_IN),
    .tQ_IN(tQ_IN), .WIM_IN(WIM_IN)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] a, b;
    logic [5:0]  op3;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [3:0]  nzvc;
  } vec_t;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Clr = 0;
    {IRE, MDRE, TBRE, nPCE, PCE, MARE, tQE, PSRE, RFE, WIME} = '1;
    {ClrPC, nPCClr, IRClr, tQClr} = '1;
    {ALUE, MFA, nPC_ADD, nPC_ADDSEL, TB_ADD, MOP_SEL, BAUX, RA_SEL, DISP_SEL, AOP_SEL, ttAUX} = '0;
    {ET, PSR_SUPER, PSR_PREV_SUP} = '0;
    {nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL, PSR_SEL, TBA_SEL} = '0;
    MDR_AUX = '0; MAR_AUX = '0; WIM_IN = '0; CWP = '0; OP1 = '0; tQ_IN = '0; TBA_IN = '0;
  endtask

  task automatic set_mdr(input logic [31:0] v);
    MDR_AUX = v; MDR_SEL = 2'd2; MDRE = 0; step(); idle();
  endtask

  task automatic set_ir(input logic [31:0] v);
    set_mdr(v); IRE = 0; step(); idle();
  endtask

  task automatic set_rf(input logic [1:0] rc, input logic [31:0] v);
    set_mdr(v); RC_SEL = rc; CIN_SEL = 2'd3; RFE = 0; step(); idle();
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
    MAR_AUX = addr; MAR_SEL = 2'd2; MARE = 0;
    MDR_AUX = data; MDR_SEL = 2'd2; MDRE = 0;
    step(); idle();
    MOP_SEL = 1; OP1 = 6'h04; MFA = 1; step();
    chk("mfc_wr_rise", {31'd0, MFC}, 32'd1);
    idle(); step();
    chk("mfc_wr_fall", {31'd0, MFC}, 32'd0);
  endtask

  task automatic mem_read(input logic [31:0] addr, input logic [31:0] expw);
    MAR_AUX = addr; MAR_SEL = 2'd2; MARE = 0; step(); idle();
    MOP_SEL = 1; OP1 = 6'h08; MFA = 1;
    exp_q.push_back(expw);
    step();
    chk("mfc_rd_rise", {31'd0, MFC}, 32'd1);
    idle(); MDR_SEL = 2'd0; MDRE = 0; step(); idle();
    chk("mfc_rd_fall", {31'd0, MFC}, 32'd0);
    chk($sformatf("mem_rd@%0h", addr), MDR, exp_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //            a             b             op3    rd     res           nzvc
    vecs[0]  = '{32'd15,        32'd17,       6'h10, 5'd3,  32'd32,       4'b0000};
    vecs[1]  = '{32'd15,        32'd15,       6'h14, 5'd4,  32'd0,        4'b0100};
    vecs[2]  = '{32'h7FFFFFFF,  32'd1,        6'h10, 5'd5,  32'h80000000, 4'b1010};
    vecs[3]  = '{32'hFFFFFFFF,  32'd1,        6'h10, 5'd6,  32'd0,        4'b0101};
    vecs[4]  = '{32'd1,         32'd1,        6'h18, 5'd7,  32'd3,        4'b0000};
    vecs[5]  = '{32'd1,         32'd2,        6'h14, 5'd8,  32'hFFFFFFFF, 4'b1001};
    vecs[6]  = '{32'd5,         32'd2,        6'h1C, 5'd9,  32'd2,        4'b0000};
    vecs[7]  = '{32'h80000000,  32'd1,        6'h04, 5'd10, 32'h7FFFFFFF, 4'b0010};
    vecs[8]  = '{32'hF0F0F0F0,  32'hFF00FF00, 6'h11, 5'd11, 32'hF000F000, 4'b1000};
    vecs[9]  = '{32'h0F0F0000,  32'h000000F0, 6'h02, 5'd0,  32'h0F0F00F0, 4'b0000};
    vecs[10] = '{32'hAAAAAAAA,  32'hAAAAAAAA, 6'h13, 5'd13, 32'd0,        4'b0100};
    vecs[11] = '{32'hFFFFFFFF,  32'h0000FFFF, 6'h05, 5'd14, 32'hFFFF0000, 4'b1000};
    vecs[12] = '{32'd0,         32'hFFFFFFFE, 6'h06, 5'd15, 32'd1,        4'b0000};
    vecs[13] = '{32'h12345678,  32'h12345678, 6'h07, 5'd16, 32'hFFFFFFFF, 4'b1000};
    vecs[14] = '{32'd1,         32'd4,        6'h25, 5'd19, 32'h10,       4'b0000};
    vecs[15] = '{32'h80000000,  32'd4,        6'h26, 5'd20, 32'h08000000, 4'b0000};
    vecs[16] = '{32'h80000000,  32'd4,        6'h27, 5'd21, 32'hF8000000, 4'b1000};

    // ---- reset ----
    idle(); Clr = 1; step(); step(); Clr = 0;
    chk("rst_ir", IR, 32'd0);
    chk("rst_psr", PSR, 32'h80);
    chk("rst_pc", PC, 32'd0);
    chk("rst_npc", nPC, 32'd0);
    chk("rst_mar_mdr", MAR | MDR, 32'd0);
    chk("rst_tbr_wim", TBR | WIM, 32'd0);
    chk("rst_tq", TQ, 32'd0);
    chk("rst_mfc", {31'd0, MFC}, 32'd0);
    nPC_ADD = 1; nPCE = 0; step(); idle();
    chk("boot_npc", nPC, 32'd4);
    chk("boot_pc", PC, 32'd0);
    PCE = 0; step(); idle();
    chk("pc_load", PC, 32'd4);
    PCE = 0; ClrPC = 0; step(); idle();
    chk("pc_clr_prio", PC, 32'd0);

    // ---- memory: store, fetch, big-endian, wrap ----
    mem_write(32'd8, 32'hA2044012);
    mem_write(32'd0, 32'hDEADBEEF);
    mem_write(32'd510, 32'h11223344);
    mem_read(32'd8, 32'hA2044012);
    IRE = 0; step(); idle();
    chk("fetch_ir", IR, 32'hA2044012);
    mem_read(32'd510, 32'h11223344);
    mem_read(32'd0, 32'h3344BEEF);

    // ---- ALU vector table; rd read back via port A with forced ADD + 0 ----
    for (int i = 0; i < 17; i++) begin
      set_rf(2'd2, vecs[i].a);
      set_rf(2'd1, vecs[i].b);
      set_ir({2'b10, vecs[i].rd, vecs[i].op3, 5'd17, 1'b0, 8'd0, 5'd18});
      chk($sformatf("alu_res[%0d]", i), ALU, vecs[i].res);
      exp_q.push_back((vecs[i].rd == 5'd0) ? 32'd0 : vecs[i].res);
      ALUE = 1; RFE = 0; CIN_SEL = 2'd2; RC_SEL = 2'd0; step(); idle();
      chk($sformatf("icc[%0d]", i), {28'd0, PSR[23:20]}, {28'd0, vecs[i].nzvc});
      AOP_SEL = 1; ALU_SEL = 2'd3; RA_SEL = 1; #1;
      chk($sformatf("rf_wb[%0d]", i), ALU, exp_q.pop_front());
      idle();
    end

    // signed 13-bit immediate
    set_rf(2'd2, 32'd100);
    set_ir({2'b10, 5'd3, 6'h00, 5'd17, 1'b1, 13'h1FFF});
    ALU_SEL = 2'd1; #1;
    chk("alu_simm", ALU, 32'd99);
    idle();

    // ---- branch ----
    Clr = 1; step(); idle();
    nPC_ADD = 1; nPCE = 0; step(); idle();
    repeat (2) begin
      PCE = 0; nPCE = 0; nPC_ADD = 1; nPC_ADDSEL = 1; step(); idle();
    end
    chk("seq_pc", PC, 32'd8);
    chk("seq_npc", nPC, 32'd12);
    set_ir(32'h3c800005);
    nPC_SEL = 2'd2; BAUX = 1; nPCE = 0; step(); idle();
    chk("br_disp22", nPC, 32'd28);
    nPC_SEL = 2'd3; BAUX = 0; nPCE = 0; step(); idle();
    chk("br_nobaux", nPC, 32'd8);
    nPC_SEL = 2'd2; BAUX = 1; DISP_SEL = 1; nPCE = 0; step(); idle();
    chk("br_disp30", nPC, 32'hF200001C);

    // ---- trap ----
    tQ_IN = 6'b001000; tQE = 0; step(); idle();
    chk("tq_set", TQ, 32'h08);
    tQ_IN = 6'b100000; tQE = 0; step(); idle();
    chk("tq_or", TQ, 32'h28);
    TBRE = 0; TBA_SEL = 2'd1; ttAUX = 1; step(); idle();
    chk("tbr_tt", TBR, 32'h40);
    RFE = 0; CIN_SEL = 2'd0; RC_SEL = 2'd2; step(); idle();
    RFE = 0; CIN_SEL = 2'd1; RC_SEL = 2'd1; step(); idle();
    set_ir({2'b10, 5'd0, 6'h00, 5'd17, 1'b0, 8'd0, 5'd18});
    AOP_SEL = 1; ALU_SEL = 2'd3; #1;
    chk("save_pc_r17", ALU, 32'd8);
    ALU_SEL = 2'd0; #1;
    chk("save_sum_r17_r18", ALU, 32'hF2000024);
    idle();
    nPC_SEL = 2'd1; nPCE = 0; step(); idle();
    chk("npc_tbr", nPC, 32'h40);
    PCE = 0; nPCE = 0; nPC_ADD = 1; nPC_ADDSEL = 1; step(); idle();
    chk("vec_pc", PC, 32'h40);
    chk("vec_npc", nPC, 32'h44);
    TBRE = 0; TBA_SEL = 2'd1; TBA_IN = 25'd1; ttAUX = 1; TB_ADD = 1; step(); idle();
    chk("tbr_tbadd", TBR, 32'h80);
    TBRE = 0; ttAUX = 1; step(); idle();
    chk("tbr_tba_hold", TBR, 32'hC0);
    tQClr = 0; tQE = 0; tQ_IN = 6'h3F; step(); idle();
    chk("tq_clr_prio", TQ, 32'd0);

    // ---- PSR / WIM ----
    PSRE = 0; PSR_SEL = 2'd1; PSR_PREV_SUP = 1; ET = 1; CWP = 5'd9; step(); idle();
    chk("psr_load", {24'd0, PSR[7:0]}, 32'h69);
    PSRE = 0; PSR_SEL = 2'd2; PSR_SUPER = 1; CWP = 5'd31; step(); idle();
    chk("psr_hold", {24'd0, PSR[7:0]}, 32'h69);
    WIME = 0; WIM_IN = 32'h5A5A00FF; step(); idle();
    chk("wim_load", WIM, 32'h5A5A00FF);

    // ---- Clr during an access cancels MFC; RAM survives ----
    MOP_SEL = 1; OP1 = 6'h08; MFA = 1; step();
    chk("mfc_pre_clr", {31'd0, MFC}, 32'd1);
    Clr = 1; step(); idle();
    chk("mfc_clr", {31'd0, MFC}, 32'd0);
    chk("psr_clr", PSR, 32'h80);
    chk("wim_clr", WIM, 32'd0);
    mem_read(32'd8, 32'hA2044012);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
